// File: rtl/dual_port_ram_fifo_ctrl.sv
// dual_port_ram_fifo_ctrl
//   Synchronous FIFO controller driving a true dual-port RAM. Port A only
//   writes, port B only reads. The controller owns pointers, occupancy count,
//   status flags and read-valid timing; the RAM holds the data and returns
//   read data one cycle after the address is presented.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               synchronous clear of pointers/count/flags
//   wr_en, wr_data      write request and data
//   rd_en               read request
//   rd_data, rd_valid   read data (passthrough of b_outdata) and its qualifier
//   full, empty         count == location / count == 0 (registered)
//   almost_full         count >= af_level (registered)
//   count               words stored
//   overflow/underflow  one-cycle pulse per rejected write/read on full/empty
//   a_*                 RAM port A (write port)
//   b_*                 RAM port B (read port), b_outdata returns RAM data
//
// Handshake: a request is taken at a rising edge when its enable is high and
// the registered flag allows it (wr: not full, rd: not empty) and flush is
// low; a rejected request produces an overflow/underflow pulse instead.
module dual_port_ram_fifo_ctrl #(
    parameter int length   = 4,
    parameter int location = 8,
    parameter int af_level = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        wr_en,
    input  logic [length-1:0]           wr_data,
    input  logic                        rd_en,
    output logic [length-1:0]           rd_data,
    output logic                        rd_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic [$clog2(location):0]   count,
    output logic                        overflow,
    output logic                        underflow,
    output logic                        a_rw,
    output logic [$clog2(location)-1:0] a_w_addr,
    output logic [length-1:0]           a_indata,
    output logic [$clog2(location)-1:0] a_r_addr,
    output logic                        b_rw,
    output logic [$clog2(location)-1:0] b_r_addr,
    output logic [$clog2(location)-1:0] b_w_addr,
    output logic [length-1:0]           b_indata,
    input  logic [length-1:0]           b_outdata
);

    localparam int AW = $clog2(location);
    localparam int CW = $clog2(location) + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic          wr_acc;
    logic          rd_acc;

    // rst_n gating makes a_rw drop the moment reset asserts, before any edge.
    assign wr_acc = rst_n & wr_en & ~full & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    // RAM drive: port B re-reads rd_ptr every cycle, which is harmless.
    assign a_rw     = wr_acc;
    assign a_w_addr = wr_ptr;
    assign a_indata = wr_data;
    assign a_r_addr = '0;
    assign b_rw     = 1'b0;
    assign b_r_addr = rd_ptr;
    assign b_w_addr = '0;
    assign b_indata = '0;

    assign rd_data = b_outdata;
    assign count   = count_q;

    always_comb begin
        count_nxt = count_q;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_nxt = count_q + CW'(1);
                2'b01:   count_nxt = count_q - CW'(1);
                default: count_nxt = count_q;
            endcase
        end
    end

    // Flags come from count_nxt so they line up with count in the same cycle.
    // Pointers wrap by explicit compare so non-power-of-2 depths work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            rd_valid    <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            count_q     <= count_nxt;
            full        <= (count_nxt == CW'(location));
            empty       <= (count_nxt == '0);
            almost_full <= (count_nxt >= CW'(af_level));
            rd_valid    <= rd_acc;
            overflow    <= wr_en & full & ~flush;
            underflow   <= rd_en & empty & ~flush;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc)
                    wr_ptr <= (wr_ptr == AW'(location - 1)) ? '0 : wr_ptr + AW'(1);
                if (rd_acc)
                    rd_ptr <= (rd_ptr == AW'(location - 1)) ? '0 : rd_ptr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dual_port_ram_fifo_ctrl.sv
// Bench for dual_port_ram_fifo_ctrl: a depth-8 instance (u_dut) and a depth-6
// instance (u_dut6), each backed by a small registered-read RAM model.
module tb_dual_port_ram_fifo_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- depth-8 instance ----------------
  logic       flush = 0, wr_en = 0, rd_en = 0;
  logic [3:0] wr_data = 0;
  logic [3:0] rd_data, a_indata, b_indata, b_outdata;
  logic       rd_valid, full, empty, almost_full, overflow, underflow, a_rw, b_rw;
  logic [3:0] count;
  logic [2:0] a_w_addr, a_r_addr, b_r_addr, b_w_addr;
  logic [3:0] mem8 [8];

  dual_port_ram_fifo_ctrl #(.length(4), .location(8), .af_level(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow), .a_rw(a_rw),
    .a_w_addr(a_w_addr), .a_indata(a_indata), .a_r_addr(a_r_addr),
    .b_rw(b_rw), .b_r_addr(b_r_addr), .b_w_addr(b_w_addr),
    .b_indata(b_indata), .b_outdata(b_outdata)
  );

  always @(posedge clk) begin
    if (a_rw) mem8[a_w_addr] <= a_indata;
    b_outdata <= mem8[b_r_addr];
  end

  // ---------------- depth-6 instance ----------------
  logic       s_flush = 0, s_wr_en = 0, s_rd_en = 0;
  logic [3:0] s_wr_data = 0;
  logic [3:0] s_rd_data, s_a_indata, s_b_indata, s_b_outdata;
  logic       s_rd_valid, s_full, s_empty, s_almost_full, s_overflow, s_underflow, s_a_rw, s_b_rw;
  logic [3:0] s_count;
  logic [2:0] s_a_w_addr, s_a_r_addr, s_b_r_addr, s_b_w_addr;
  logic [3:0] mem6 [6];

  dual_port_ram_fifo_ctrl #(.length(4), .location(6), .af_level(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .wr_en(s_wr_en), .wr_data(s_wr_data),
    .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
    .empty(s_empty), .almost_full(s_almost_full), .count(s_count),
    .overflow(s_overflow), .underflow(s_underflow), .a_rw(s_a_rw),
    .a_w_addr(s_a_w_addr), .a_indata(s_a_indata), .a_r_addr(s_a_r_addr),
    .b_rw(s_b_rw), .b_r_addr(s_b_r_addr), .b_w_addr(s_b_w_addr),
    .b_indata(s_b_indata), .b_outdata(s_b_outdata)
  );

  always @(posedge clk) begin
    if (s_a_rw && s_a_w_addr < 3'd6) mem6[s_a_w_addr] <= s_a_indata;
    if (s_b_r_addr < 3'd6) s_b_outdata <= mem6[s_b_r_addr];
  end

  logic [3:0] exp_q [$];

  // advance one edge, land 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({count, empty, full, almost_full, rd_valid, overflow, underflow} !== {4'd0, 6'b100000}) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d e=%b f=%b af=%b rv=%b ov=%b un=%b, want count=0 e=1 others 0",
               count, empty, full, almost_full, rd_valid, overflow, underflow);
    end
    n_checks++;
    if ({s_count, s_empty} !== {4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state6: count=%0d empty=%b, want 0/1", s_count, s_empty);
    end
    n_checks++;
    if ({b_rw, a_r_addr, b_w_addr, b_indata} !== 11'd0) begin
      n_fail++;
      $display("FAIL tied_ports: b_rw=%b a_r_addr=%0d b_w_addr=%0d b_indata=%h, want 0",
               b_rw, a_r_addr, b_w_addr, b_indata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1;
      wr_data = 4'(i);
      #1;
      n_checks++;
      if (a_rw !== 1'b1 || a_w_addr !== 3'(i - 1) || a_indata !== 4'(i)) begin
        n_fail++;
        $display("FAIL fill_ram_drive[%0d]: a_rw=%b addr=%0d data=%h, want 1/%0d/%h",
                 i, a_rw, a_w_addr, a_indata, i - 1, i);
      end
      tick();
      n_checks++;
      if (count !== 4'(i) || almost_full !== (i >= 6) || full !== (i == 8) || empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_flags[%0d]: count=%0d af=%b full=%b empty=%b, want %0d/%b/%b/0",
                 i, count, almost_full, full, empty, i, i >= 6, i == 8);
      end
    end
  endtask

  task automatic test_overflow();
    wr_en = 1'b1;
    wr_data = 4'h9;
    #1;
    n_checks++;
    if (a_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_a_rw: got %b want 0", a_rw);
    end
    tick();
    n_checks++;
    if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pulse: ov=%b count=%0d full=%b, want 1/8/1", overflow, count, full);
    end
    wr_en = 1'b0;
    tick();
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_not_sticky: got %b want 0", overflow);
    end
  endtask

  task automatic test_drain();
    for (int k = 1; k <= 8; k++) begin
      rd_en = 1'b1;
      #1;
      n_checks++;
      if (b_r_addr !== 3'(k - 1)) begin
        n_fail++;
        $display("FAIL drain_addr[%0d]: got %0d want %0d", k, b_r_addr, k - 1);
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 4'(k) || count !== 4'(8 - k)) begin
        n_fail++;
        $display("FAIL drain_data[%0d]: rv=%b data=%h count=%0d, want 1/%h/%0d",
                 k, rd_valid, rd_data, count, k, 8 - k);
      end
    end
    rd_en = 1'b0;
    tick();
    n_checks++;
    if (rd_valid !== 1'b0 || empty !== 1'b1 || almost_full !== 1'b0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_end: rv=%b empty=%b af=%b full=%b, want 0/1/0/0",
               rd_valid, empty, almost_full, full);
    end
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    tick();
    n_checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || b_r_addr !== 3'd0 || a_w_addr !== 3'd0 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL underflow: un=%b rv=%b rptr=%0d wptr=%0d count=%0d, want 1/0/0/0/0",
               underflow, rd_valid, b_r_addr, a_w_addr, count);
    end
    rd_en = 1'b0;
    tick();
    n_checks++;
    if (underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_not_sticky: got %b want 0", underflow);
    end
  endtask

  task automatic test_stream_wrap();
    exp_q.delete();
    for (int k = 0; k <= 20; k++) begin
      s_wr_en = (k < 20);
      s_wr_data = 4'(k * 7 + 3);
      s_rd_en = (k > 0);
      if (s_wr_en) exp_q.push_back(4'(k * 7 + 3));
      tick();
      n_checks++;
      if (s_count !== ((k < 20) ? 4'd1 : 4'd0) || s_overflow !== 1'b0 || s_underflow !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_count[%0d]: count=%0d ov=%b un=%b, want %0d/0/0",
                 k, s_count, s_overflow, s_underflow, (k < 20) ? 1 : 0);
      end
      if (k > 0) begin
        logic [3:0] exp_w;
        exp_w = exp_q.pop_front();
        n_checks++;
        if (s_rd_valid !== 1'b1 || s_rd_data !== exp_w) begin
          n_fail++;
          $display("FAIL stream_data[%0d]: rv=%b data=%h, want 1/%h", k, s_rd_valid, s_rd_data, exp_w);
        end
      end
    end
    s_wr_en = 1'b0;
    s_rd_en = 1'b0;
    tick();
    n_checks++;
    if (s_empty !== 1'b1 || s_rd_valid !== 1'b0 || s_b_r_addr !== 3'd2 || s_a_w_addr !== 3'd2) begin
      n_fail++;
      $display("FAIL stream_end: empty=%b rv=%b rptr=%0d wptr=%0d, want 1/0/2/2",
               s_empty, s_rd_valid, s_b_r_addr, s_a_w_addr);
    end
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = 4'(4'hA + i);
      tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 4'hA || count !== 4'd2) begin
      n_fail++;
      $display("FAIL pre_reset_read: rv=%b data=%h count=%0d, want 1/a/2", rd_valid, rd_data, count);
    end
    #2;
    rst_n = 1'b0;
    wr_en = 1'b1;
    #1;
    n_checks++;
    if (count !== 4'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || a_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: count=%0d empty=%b rv=%b a_rw=%b, want 0/1/0/0",
               count, empty, rd_valid, a_rw);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (count !== 4'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: count=%0d empty=%b rv=%b, want 0/1/0", count, empty, rd_valid);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_data = 4'(i + 1);
      tick();
    end
    n_checks++;
    if (count !== 4'd5 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_flush: count=%0d af=%b, want 5/0", count, almost_full);
    end
    flush = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    #1;
    n_checks++;
    if (a_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_a_rw: got %b want 0", a_rw);
    end
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
        rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 ||
        a_w_addr !== 3'd0 || b_r_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_state: count=%0d e=%b f=%b af=%b rv=%b ov=%b un=%b wptr=%0d rptr=%0d, want 0/1/0/0/0/0/0/0/0",
               count, empty, full, almost_full, rd_valid, overflow, underflow, a_w_addr, b_r_addr);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_stream_wrap();
    test_reset_mid_read();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
